// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the UART debug host: FSM encodings, command codes,
// frame sizes and the request-frame byte selector.
package dbg_uart_pkg;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int         TX_BYTES  = 9;
    localparam int         RSP_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_DONE
    } host_state_e;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Byte idx of the outgoing frame: cmd, addr LSB..MSB, data LSB..MSB.
    function automatic logic [7:0] tx_byte_sel(input logic [7:0]  cmd,
                                               input logic [31:0] addr,
                                               input logic [31:0] data,
                                               input logic [3:0]  idx);
        logic [71:0] frame;
        frame = {data, addr, cmd};
        return frame[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dbg_uart_host_if.sv
// Request/response bus of the UART debug host, as seen by a requester (master)
// and by the host itself (slave).
interface dbg_uart_host_if;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_err;

    modport master (
        output cmd, addr, data, req_valid,
        input  req_ready, rsp_data, rsp_valid, rsp_err
    );

    modport slave (
        input  cmd, addr, data, req_valid,
        output req_ready, rsp_data, rsp_valid, rsp_err
    );
endinterface

// File: rtl/dbg_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, falling-edge start detect with mid-bit
// confirmation, LSB-first sampling and a stop-bit framing check. Only hunts while en_i.
module dbg_uart_rx_byte
    import dbg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       en_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          meta_q, sync_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_HUNT;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        valid_o     = 1'b0;
        frame_err_o = 1'b0;
        case (state_q)
            RX_HUNT: begin
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at half a bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_HUNT : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {sync_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    valid_o     = en_i & sync_q;
                    frame_err_o = en_i & ~sync_q;
                    state_d     = RX_HUNT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (!en_i) state_d = RX_HUNT;
    end

    assign byte_o = shreg_q;

endmodule

// File: rtl/dbg_uart_host.sv
// UART debug host: serializes a 9-byte command frame (cmd, addr, data) and collects a
// 4-byte reply, reporting framing errors and a whole-response timeout as rsp_err_o.
module dbg_uart_host
    import dbg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  cmd_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    BYTE_LAST = 4'(TX_BYTES - 1);
    localparam logic [1:0]    RSP_LAST  = 2'(RSP_BYTES - 1);

    host_state_e   state_q, state_d;
    logic          ready_q, ready_d;
    logic          tx_q, tx_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    rsp_cnt_q, rsp_cnt_d;
    logic [23:0]   rsp_shift_q, rsp_shift_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_valid_q, rsp_valid_d;

    logic [7:0]    cur_byte;
    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;

    assign cur_byte = tx_byte_sel(cmd_q, addr_q, data_q, byte_idx_q);

    dbg_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .en_i        (state_q == ST_RX),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            tx_q        <= 1'b1;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            clk_cnt_q   <= '0;
            to_cnt_q    <= '0;
            rsp_cnt_q   <= '0;
            rsp_shift_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            clk_cnt_q   <= clk_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_shift_q <= rsp_shift_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = 1'b1;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        clk_cnt_d   = clk_cnt_q;
        to_cnt_d    = to_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        rsp_shift_d = rsp_shift_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d    = ST_TX;
                    cmd_d      = cmd_i;
                    addr_d     = addr_i;
                    data_d     = data_i;
                    tx_d       = 1'b0;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    clk_cnt_d  = '0;
                end
            end
            ST_TX: begin
                // tx_q already holds the current bit; the next one is loaded at bit end.
                tx_d = tx_q;
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        if (byte_idx_q == BYTE_LAST) begin
                            state_d   = ST_RX;
                            tx_d      = 1'b1;
                            to_cnt_d  = '0;
                            rsp_cnt_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            bit_idx_d  = '0;
                            tx_d       = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_RX: begin
                if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
                // A final byte landing on the timeout cycle still counts as success.
                if (rx_valid && rsp_cnt_q == RSP_LAST) begin
                    state_d     = ST_DONE;
                    rsp_data_d  = {rx_byte, rsp_shift_q};
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (rx_ferr || to_cnt_q == TO_LAST) begin
                    state_d     = ST_DONE;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                end else if (rx_valid) begin
                    rsp_shift_d = {rx_byte, rsp_shift_q[23:8]};
                    rsp_cnt_d   = rsp_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    assign req_ready_o = ready_q;
    assign uart_tx_o   = tx_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_valid_o = rsp_valid_q;

endmodule

// File: doc/dbg_uart_host.md
DBG_UART_HOST -- requirements
Module: dbg_uart_host

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536, meaning the response timeout in cycles.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port cmd_i, input, 8 bits: debug command byte.
REQ-007 SHALL have port addr_i, input, 32 bits: debug address.
REQ-008 SHALL have port data_i, input, 32 bits: debug write data.
REQ-009 SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-010 SHALL have port req_ready_o, output, 1 bit: request accepted when high together with req_valid_i.
REQ-011 SHALL have port rsp_data_o, output, 32 bits: response word.
REQ-012 SHALL have port rsp_valid_o, output, 1 bit: one-cycle response strobe.
REQ-013 SHALL have port rsp_err_o, output, 1 bit: response error, qualified by rsp_valid_o.
REQ-014 SHALL have port uart_tx_o, output, 1 bit: serial line to the debug target's rx.
REQ-015 SHALL have port uart_rx_i, input, 1 bit: serial line from the debug target's tx; asynchronous.

Function
REQ-016 SHALL implement FSM states IDLE, TX, RX, DONE with transitions IDLE->TX on handshake, TX->RX after the last stop bit, RX->DONE on the 4th byte, a framing error or a timeout, and DONE->IDLE after one cycle.
REQ-017 SHALL drive req_ready_o high only in IDLE and capture cmd_i/addr_i/data_i on the req_valid_i && req_ready_o cycle.
REQ-018 SHALL send 9 bytes in order: cmd, addr[7:0], addr[15:8], addr[23:16], addr[31:24], data[7:0] .. data[31:24].
REQ-019 SHALL frame each byte 8N1: start bit 0, data LSB first, stop bit 1, each bit CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-020 SHALL drive the first start bit on the cycle after the handshake, giving a TX phase of exactly 90*CLKS_PER_BIT cycles.
REQ-021 SHALL hold uart_tx_o at 1 outside TX.
REQ-022 SHALL pass uart_rx_i through a 2-flop synchronizer before use.
REQ-023 SHALL ignore rx activity outside RX, including a byte partially in flight at TX->RX.
REQ-024 SHALL detect a start bit in RX as a synchronized falling edge and re-sample it at CLKS_PER_BIT/2; if the line is high again it is a false start and the receiver returns to hunting.
REQ-025 SHALL sample data bits at mid-bit, LSB first.
REQ-026 SHALL treat a stop-bit sample of 0 as a framing error: go to DONE with rsp_err_o=1 and rsp_data_o=0.
REQ-027 SHALL assemble 4 received bytes LSB first into rsp_data_o.
REQ-028 SHALL count the timeout from RX entry and never restart it per byte.
REQ-029 SHALL, when TIMEOUT_CYCLES elapse before the 4th stop bit is sampled, go to DONE with rsp_err_o=1 and rsp_data_o=0.
REQ-030 SHALL, on simultaneous completion of the 4th byte and timeout expiry, treat the response as valid with rsp_err_o=0.
REQ-031 SHALL pulse rsp_valid_o for exactly one cycle in DONE.
REQ-032 SHALL hold rsp_data_o/rsp_err_o stable until the next response.
REQ-033 SHALL accept the next request no earlier than the cycle after DONE.
REQ-034 SHALL implement all bit and timeout counters as unsigned values that never wrap mid-frame, sized from the parameters.

Reset
REQ-035 SHALL, while rstn_i is low, immediately force state IDLE, uart_tx_o=1, req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0 and all counters and the synchronizer to idle (synchronizer to 1).
REQ-036 SHALL abort a transfer on reset mid-operation with no response strobe, and drive req_ready_o=1 from the first clock edge after reset release.

Structure
REQ-037 SHALL place the state enum, CMD_READ=8'h01, CMD_WRITE=8'h02, TX_BYTES=9 and RSP_BYTES=4 in package dbg_uart_pkg.
REQ-038 SHALL implement the receive path (synchronizer, start detect, mid-bit sampling, framing check) as sub-module dbg_uart_rx_byte with a byte/valid/frame_err output; the transmit serializer stays inline.

Verification (CLKS_PER_BIT=4, TIMEOUT_CYCLES=2000)
REQ-039 SHALL cover: read request cmd=01, addr=0x1000_0004; loopback model replies 0xDEADBEEF -> line shows bytes 01,04,00,00,10,data bytes, 360 TX cycles; rsp_valid_o pulses once with rsp_data_o=0xDEADBEEF, rsp_err_o=0.
REQ-040 SHALL cover: no reply from target -> rsp_valid_o with rsp_err_o=1 and rsp_data_o=0 exactly 2000 cycles after RX entry.
REQ-041 SHALL cover: 3rd response byte with stop bit 0 -> rsp_err_o=1 immediately after that stop sample, rsp_data_o=0.
REQ-042 SHALL cover: a 1-cycle low glitch on uart_rx_i in RX followed by a valid reply of 0x12345678 -> glitch ignored, rsp_data_o=0x12345678, rsp_err_o=0.
REQ-043 SHALL cover: rstn_i asserted mid-TX at byte 3 -> uart_tx_o=1 immediately, no rsp_valid_o; a new request after release completes normally.
REQ-044 SHALL cover: req_valid_i held high across back-to-back requests -> req_ready_o low during TX/RX/DONE, exactly one handshake per response, and the second request's start bit on the cycle after its handshake.
